ysyx_22040237_lsu: RTL and testbench
====================================

YSYX_22040237_LSU -- requirements
Module: ysyx_22040237_lsu

Interface
REQ-001 Parameter TIMEOUT_CYC, default 255: max cycles in REQ+WAIT before the access aborts; legal range 1..255; counter is 8 bits.
REQ-002 Data width SHALL be `ysyx_22040237_REG_WIDTH (64); shown below as 64.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 in_valid_i  in  1  EXU result valid.
REQ-006 in_ready_o  out  1  LSU accepts EXU result.
REQ-007 mem_rd_en_i  in  1  load op.
REQ-008 mem_wr_en_i  in  1  store op.
REQ-009 func3_i  in  3  RV64 size/sign: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU.
REQ-010 addr_i  in  64  effective address.
REQ-011 wdata_i  in  64  store data, LSB-justified.
REQ-012 rd_wr_en_i / rd_idx_i / rd_data_i  in  1/5/64  ALU writeback info.
REQ-013 dmem_req_o, dmem_we_o  out  1/1  bus request, write strobe.
REQ-014 dmem_addr_o  out  64  addr_i with bits [2:0] forced to 0.
REQ-015 dmem_wdata_o, dmem_wmask_o  out  64/8  lane-shifted store data, byte mask.
REQ-016 dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i  in  1/1/64  grant, read-data valid, read data.
REQ-017 out_valid_o, rd_wr_en_o, rd_idx_o, rd_data_o, lsu_err_o  out  1/1/5/64/1  result to WBU.

Function
REQ-018 States SHALL be IDLE, REQ, WAIT, RESP; in_ready_o=1 only in IDLE.
REQ-019 Accept = in_valid_i & in_ready_o; all inputs captured into registers on accept.
REQ-020 Accept with neither mem enable: go RESP; next cycle out_valid_o=1, rd_*_o = captured rd_*_i, lsu_err_o=0.
REQ-021 Misaligned access (H: addr[0]!=0; W/WU: addr[1:0]!=0; D: addr[2:0]!=0), both enables set, or func3 111 on load / >011 on store: go RESP, no bus request, lsu_err_o=1, rd_wr_en_o=0.
REQ-022 Valid mem op: go REQ; dmem_req_o=1 held, and addr/we/wdata/wmask held stable, until dmem_gnt_i=1.
REQ-023 Store: wmask = size mask (0x01/0x03/0x0F/0xFF) << addr[2:0]; wdata = wdata_i << (8*addr[2:0]); on gnt go RESP with rd_wr_en_o=0.
REQ-024 Load: on gnt go WAIT; on dmem_rvalid_i select lane at addr[2:0], sign-extend (B/H/W) or zero-extend (BU/HU/WU/D) to 64, go RESP with rd_data_o=result, rd_wr_en_o=captured rd_wr_en_i.
REQ-025 dmem_rvalid_i outside WAIT SHALL be ignored; rvalid in the gnt cycle is not sampled.
REQ-026 Timeout counter clears on accept, increments each cycle in REQ/WAIT; reaching TIMEOUT_CYC forces RESP with lsu_err_o=1, rd_wr_en_o=0, dmem_req_o dropped.
REQ-027 RESP lasts exactly one cycle (out_valid_o single-cycle pulse), then IDLE; WBU always accepts.
REQ-028 Latency from accept cycle T: non-mem/error out_valid at T+1; store with gnt at T+1 -> out_valid T+2; load with gnt T+1, rvalid T+2 -> out_valid T+3.
REQ-029 rd_idx_o SHALL equal captured rd_idx_i even when rd_wr_en_o=0.

Reset
REQ-030 On rst=1 at a clock edge: state=IDLE, counter=0, in_ready_o=1 the following cycle, all outputs 0 (dmem_req_o, out_valid_o, rd_wr_en_o, rd_idx_o, rd_data_o, lsu_err_o, dmem_*_o).
REQ-031 rst mid-transaction (REQ or WAIT) SHALL abandon the access without emitting out_valid_o; a later rvalid SHALL be ignored.

Verification
REQ-032 ALU op rd_idx=5, rd_data=0x1234, rd_wr_en=1 -> out_valid T+1, rd_data_o=0x1234, err=0.
REQ-033 LB addr=0x8000_0003, rdata=0x0000_0000_8000_0000 -> lane 3 byte 0x80, rd_data_o=0xFFFF_FFFF_FFFF_FF80; same with LBU -> 0x80.
REQ-034 SH addr=0x8000_0006, wdata=0xABCD -> dmem_addr=0x8000_0000, wmask=0xC0, wdata=0xABCD_0000_0000_0000, out_valid with rd_wr_en_o=0.
REQ-035 LW addr=0x8000_0002 -> no dmem_req, out_valid T+1, lsu_err_o=1, rd_wr_en_o=0.
REQ-036 LD with gnt withheld 3 cycles, rvalid 2 cycles later, rdata=0x0123_4567_89AB_CDEF -> req held stable 4 cycles, out_valid T+7, rd_data_o=0x0123_4567_89AB_CDEF.
REQ-037 TIMEOUT_CYC=4, no gnt -> out_valid with lsu_err_o=1 at T+5; rst asserted in WAIT -> IDLE, no out_valid.

Source files
------------

// File: rtl/ysyx_22040237_lsu.sv
// Load/store unit: one outstanding access on a req/gnt/rvalid data bus.
// Also passes ALU results through to writeback.
`ifndef ysyx_22040237_REG_WIDTH
`define ysyx_22040237_REG_WIDTH 64
`endif

module ysyx_22040237_lsu #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic        mem_rd_en_i,
  input  logic        mem_wr_en_i,
  input  logic [2:0]  func3_i,
  input  logic [`ysyx_22040237_REG_WIDTH-1:0] addr_i,
  input  logic [`ysyx_22040237_REG_WIDTH-1:0] wdata_i,
  input  logic        rd_wr_en_i,
  input  logic [4:0]  rd_idx_i,
  input  logic [`ysyx_22040237_REG_WIDTH-1:0] rd_data_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [`ysyx_22040237_REG_WIDTH-1:0] dmem_addr_o,
  output logic [`ysyx_22040237_REG_WIDTH-1:0] dmem_wdata_o,
  output logic [7:0]  dmem_wmask_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [`ysyx_22040237_REG_WIDTH-1:0] dmem_rdata_i,
  output logic        out_valid_o,
  output logic        rd_wr_en_o,
  output logic [4:0]  rd_idx_o,
  output logic [`ysyx_22040237_REG_WIDTH-1:0] rd_data_o,
  output logic        lsu_err_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_RESP
  } state_e;

  state_e      state_q;
  logic [7:0]  cnt_q;
  logic [2:0]  f3_q;
  logic [2:0]  off_q;
  logic        rdwe_q;

  logic        mis_d;
  logic        bad_d;
  logic [7:0]  smask_d;
  logic [7:0]  wmask_d;
  logic [63:0] wdata_d;
  logic [63:0] lane_d;
  logic [63:0] ld_d;
  logic        tmo_d;

  assign in_ready_o = (state_q == S_IDLE);

  always_comb begin
    mis_d   = 1'b0;
    smask_d = 8'h01;
    unique case (func3_i[1:0])
      2'b00: smask_d = 8'h01;
      2'b01: begin
        smask_d = 8'h03;
        mis_d   = addr_i[0];
      end
      2'b10: begin
        smask_d = 8'h0F;
        mis_d   = |addr_i[1:0];
      end
      default: begin
        smask_d = 8'hFF;
        mis_d   = |addr_i[2:0];
      end
    endcase
    bad_d = mis_d
          | (mem_rd_en_i & mem_wr_en_i)
          | (mem_rd_en_i & (func3_i == 3'b111))
          | (mem_wr_en_i & func3_i[2]);
    wmask_d = smask_d << addr_i[2:0];
    wdata_d = wdata_i << {addr_i[2:0], 3'b000};
  end

  always_comb begin
    lane_d = dmem_rdata_i >> {off_q, 3'b000};
    ld_d   = lane_d;
    unique case (f3_q)
      3'b000: ld_d = {{56{lane_d[7]}}, lane_d[7:0]};
      3'b001: ld_d = {{48{lane_d[15]}}, lane_d[15:0]};
      3'b010: ld_d = {{32{lane_d[31]}}, lane_d[31:0]};
      3'b100: ld_d = {56'd0, lane_d[7:0]};
      3'b101: ld_d = {48'd0, lane_d[15:0]};
      3'b110: ld_d = {32'd0, lane_d[31:0]};
      default: ld_d = lane_d;
    endcase
  end

  // Counter value after this cycle reaching the limit aborts the access.
  assign tmo_d = ({1'b0, cnt_q} + 9'd1) >= 9'(TIMEOUT_CYC);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= 8'd0;
      f3_q         <= 3'd0;
      off_q        <= 3'd0;
      rdwe_q       <= 1'b0;
      dmem_req_o   <= 1'b0;
      dmem_we_o    <= 1'b0;
      dmem_addr_o  <= '0;
      dmem_wdata_o <= '0;
      dmem_wmask_o <= 8'd0;
      out_valid_o  <= 1'b0;
      rd_wr_en_o   <= 1'b0;
      rd_idx_o     <= 5'd0;
      rd_data_o    <= '0;
      lsu_err_o    <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (in_valid_i) begin
            cnt_q    <= 8'd0;
            f3_q     <= func3_i;
            off_q    <= addr_i[2:0];
            rdwe_q   <= rd_wr_en_i;
            rd_idx_o <= rd_idx_i;
            if (!mem_rd_en_i && !mem_wr_en_i) begin
              state_q     <= S_RESP;
              out_valid_o <= 1'b1;
              rd_wr_en_o  <= rd_wr_en_i;
              rd_data_o   <= rd_data_i;
              lsu_err_o   <= 1'b0;
            end else if (bad_d) begin
              state_q     <= S_RESP;
              out_valid_o <= 1'b1;
              rd_wr_en_o  <= 1'b0;
              rd_data_o   <= '0;
              lsu_err_o   <= 1'b1;
            end else begin
              state_q      <= S_REQ;
              dmem_req_o   <= 1'b1;
              dmem_we_o    <= mem_wr_en_i;
              dmem_addr_o  <= {addr_i[63:3], 3'b000};
              dmem_wdata_o <= wdata_d;
              dmem_wmask_o <= wmask_d;
            end
          end
        end
        S_REQ: begin
          cnt_q <= cnt_q + 8'd1;
          if (tmo_d || dmem_gnt_i) begin
            dmem_req_o <= 1'b0;
          end
          if (tmo_d || (dmem_gnt_i && dmem_we_o)) begin
            state_q     <= S_RESP;
            out_valid_o <= 1'b1;
            rd_wr_en_o  <= 1'b0;
            rd_data_o   <= '0;
            lsu_err_o   <= tmo_d;
          end else if (dmem_gnt_i) begin
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q + 8'd1;
          if (tmo_d) begin
            state_q     <= S_RESP;
            out_valid_o <= 1'b1;
            rd_wr_en_o  <= 1'b0;
            rd_data_o   <= '0;
            lsu_err_o   <= 1'b1;
          end else if (dmem_rvalid_i) begin
            state_q     <= S_RESP;
            out_valid_o <= 1'b1;
            rd_wr_en_o  <= rdwe_q;
            rd_data_o   <= ld_d;
            lsu_err_o   <= 1'b0;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          out_valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22040237_lsu.sv
// Bench for the LSU: directed spec cases plus random transactions
// checked against an arithmetic model of load/store semantics.
module tb_ysyx_22040237_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_valid_b;
  logic        mem_rd, mem_wr;
  logic [2:0]  f3;
  logic [63:0] addr, wdata;
  logic        rwe;
  logic [4:0]  ridx;
  logic [63:0] rdat_alu;
  logic        gnt, rvalid;
  logic [63:0] rdata;

  logic        in_ready, req, we, ov, rwe_o, err;
  logic [63:0] daddr, dwdata, rd_data_o;
  logic [7:0]  wmask;
  logic [4:0]  ridx_o;

  logic        in_ready_b, req_b, we_b, ov_b, rwe_b, err_b;
  logic [63:0] daddr_b, dwdata_b, rdo_b;
  logic [7:0]  wmask_b;
  logic [4:0]  ridx_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ysyx_22040237_lsu dut (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .mem_rd_en_i(mem_rd), .mem_wr_en_i(mem_wr),
    .func3_i(f3), .addr_i(addr), .wdata_i(wdata),
    .rd_wr_en_i(rwe), .rd_idx_i(ridx), .rd_data_i(rdat_alu),
    .dmem_req_o(req), .dmem_we_o(we), .dmem_addr_o(daddr),
    .dmem_wdata_o(dwdata), .dmem_wmask_o(wmask),
    .dmem_gnt_i(gnt), .dmem_rvalid_i(rvalid), .dmem_rdata_i(rdata),
    .out_valid_o(ov), .rd_wr_en_o(rwe_o), .rd_idx_o(ridx_o),
    .rd_data_o(rd_data_o), .lsu_err_o(err)
  );

  ysyx_22040237_lsu #(.TIMEOUT_CYC(4)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid_b), .in_ready_o(in_ready_b),
    .mem_rd_en_i(mem_rd), .mem_wr_en_i(mem_wr),
    .func3_i(f3), .addr_i(addr), .wdata_i(wdata),
    .rd_wr_en_i(rwe), .rd_idx_i(ridx), .rd_data_i(rdat_alu),
    .dmem_req_o(req_b), .dmem_we_o(we_b), .dmem_addr_o(daddr_b),
    .dmem_wdata_o(dwdata_b), .dmem_wmask_o(wmask_b),
    .dmem_gnt_i(gnt), .dmem_rvalid_i(rvalid), .dmem_rdata_i(rdata),
    .out_valid_o(ov_b), .rd_wr_en_o(rwe_b), .rd_idx_o(ridx_b),
    .rd_data_o(rdo_b), .lsu_err_o(err_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One transaction: g = cycles gnt is withheld, r = WAIT cycles before rvalid.
  task automatic txn(input logic rd, input logic wr, input logic [2:0] fn,
                     input logic [63:0] a, input logic [63:0] wd,
                     input logic we_in, input logic [4:0] idx,
                     input logic [63:0] alu, input logic [63:0] mem,
                     input int g, input int r, input string tag);
    int sz, lat, exp_lat;
    logic [2:0] off;
    logic bad, ok, saw;
    logic [63:0] vm, v, exp_d, exp_wd;
    logic [7:0] exp_m;
    sz  = 1 << fn[1:0];
    off = a[2:0];
    bad = (rd && wr) || (rd && fn == 3'b111) || (wr && fn > 3'b011)
       || ((rd || wr) && (a % sz != 0));
    ok  = (rd || wr) && !bad;
    exp_lat = !ok ? 1 : (wr ? g + 2 : g + 3 + r);
    exp_m   = 8'(((16'd1 << sz) - 16'd1) << off);
    exp_wd  = wd << (8 * off);
    vm = (sz == 8) ? {64{1'b1}} : ((64'd1 << (8 * sz)) - 64'd1);
    v  = (mem >> (8 * off)) & vm;
    if (!fn[2] && sz < 8 && v[8 * sz - 1]) v = v | ~vm;
    exp_d = rd ? v : alu;

    @(negedge clk);
    chk({tag, ":ready"}, in_ready, 1);
    in_valid = 1; mem_rd = rd; mem_wr = wr; f3 = fn; addr = a;
    wdata = wd; rwe = we_in; ridx = idx; rdat_alu = alu;
    lat = 0; saw = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) begin
        in_valid = 0;
        addr = {$urandom, $urandom};
        wdata = {$urandom, $urandom};
        f3 = 3'($urandom);
      end
      if (req) begin
        saw = 1;
        chk({tag, ":daddr"}, daddr, {a[63:3], 3'b000});
        chk({tag, ":we"}, we, wr);
        if (wr) begin
          chk({tag, ":wmask"}, wmask, exp_m);
          chk({tag, ":wdata"}, dwdata, exp_wd);
        end
      end
      if (ov) begin
        lat = k;
        break;
      end
      gnt    = ok && (k == g + 1);
      rvalid = ok && ((k <= g + 1) || (rd && k == g + 2 + r));
      rdata  = (rd && k == g + 2 + r) ? mem : {$urandom, $urandom};
    end
    gnt = 0; rvalid = 0;
    chk({tag, ":latency"}, lat, exp_lat);
    chk({tag, ":bus_used"}, saw, ok);
    chk({tag, ":err"}, err, bad);
    chk({tag, ":rd_wr_en"}, rwe_o, (bad || wr) ? 1'b0 : we_in);
    chk({tag, ":rd_idx"}, ridx_o, idx);
    if (!bad && !wr) chk({tag, ":rd_data"}, rd_data_o, exp_d);
    @(negedge clk);
    chk({tag, ":pulse"}, ov, 0);
  endtask

  initial begin
    int lat;
    logic seen, r4, r5;
    rst = 1; in_valid = 0; in_valid_b = 0; mem_rd = 0; mem_wr = 0;
    f3 = 0; addr = 0; wdata = 0; rwe = 0; ridx = 0; rdat_alu = 0;
    gnt = 0; rvalid = 0; rdata = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    chk("rst:ready", in_ready, 1);
    chk("rst:req", req, 0);
    chk("rst:ov", ov, 0);
    chk("rst:err", err, 0);
    chk("rst:rd_data", rd_data_o, 0);
    chk("rst:wmask", wmask, 0);

    txn(0, 0, 3'b000, 0, 0, 1, 5, 64'h1234, 0, 0, 0, "alu");
    txn(1, 0, 3'b000, 64'h8000_0003, 0, 1, 7, 0,
        64'h0000_0000_8000_0000, 0, 0, "lb");
    txn(1, 0, 3'b100, 64'h8000_0003, 0, 1, 7, 0,
        64'h0000_0000_8000_0000, 0, 0, "lbu");
    txn(0, 1, 3'b001, 64'h8000_0006, 64'hABCD, 1, 3, 0, 0, 0, 0, "sh");
    txn(1, 0, 3'b010, 64'h8000_0002, 0, 1, 9, 0, 0, 0, 0, "lw_mis");
    txn(1, 0, 3'b011, 64'h8000_0000, 0, 1, 10, 0,
        64'h0123_4567_89AB_CDEF, 3, 1, "ld_slow");
    txn(1, 0, 3'b111, 64'h8000_0000, 0, 1, 11, 0, 0, 0, 0, "ld_f7");
    txn(0, 1, 3'b100, 64'h8000_0000, 1, 1, 12, 0, 0, 0, 0, "st_f4");
    txn(1, 1, 3'b000, 64'h8000_0000, 1, 1, 13, 0, 0, 0, 0, "both");

    for (int i = 0; i < 40; i++) begin
      logic rd, wr;
      logic [2:0] fn;
      logic [63:0] a;
      int kind;
      kind = $urandom_range(0, 9);
      rd = (kind < 4) || (kind == 9);
      wr = (kind >= 4 && kind < 8) || (kind == 9);
      fn = 3'($urandom);
      a  = {32'h0, 32'h8000_0000 | 32'($urandom_range(0, 255))};
      if ($urandom_range(0, 2) != 0) a = a & ~((64'd1 << fn[1:0]) - 64'd1);
      txn(rd, wr, fn, a, {$urandom, $urandom}, 1'($urandom),
          5'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
          $urandom_range(0, 4), $urandom_range(0, 3), "rand");
    end

    // Timeout on the TIMEOUT_CYC=4 instance; the bus never grants.
    @(negedge clk);
    chk("tmo:ready", in_ready_b, 1);
    in_valid_b = 1; mem_rd = 0; mem_wr = 1; f3 = 3'b011;
    addr = 64'h8000_0010; wdata = 64'h55; ridx = 5'd4; rwe = 1;
    lat = 0; r4 = 0; r5 = 1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      in_valid_b = 0;
      if (k == 4) r4 = req_b;
      if (k == 5) r5 = req_b;
      if (ov_b) begin
        lat = k;
        break;
      end
    end
    chk("tmo:latency", lat, 5);
    chk("tmo:err", err_b, 1);
    chk("tmo:rd_wr_en", rwe_b, 0);
    chk("tmo:req_held", r4, 1);
    chk("tmo:req_dropped", r5, 0);

    // Reset while a load sits in WAIT; the late rvalid must be ignored.
    @(negedge clk);
    in_valid = 1; mem_rd = 1; mem_wr = 0; f3 = 3'b011;
    addr = 64'h8000_0020; rwe = 1; ridx = 5'd6;
    @(negedge clk);
    in_valid = 0; gnt = 1;
    @(negedge clk);
    chk("rstw:in_wait", in_ready, 0);
    gnt = 0; rst = 1;
    @(negedge clk);
    rst = 0; rvalid = 1; rdata = 64'hDEAD_BEEF_0000_0001;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (ov) seen = 1;
    end
    rvalid = 0;
    chk("rstw:no_out", seen, 0);
    chk("rstw:ready", in_ready, 1);
    chk("rstw:req", req, 0);
    chk("rstw:rd_data", rd_data_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
